// File: rtl/msk_cols_bundle_serdes_if.sv
// msk_cols_bundle_serdes_if
//   Handshake bundle for the column/bundle serial converter.
//   Input side : in_valid, in_ready, in_mode, in_data (WC sharings of D shares)
//   Output side: out_valid, out_ready, out_data (same packing as in_data)
//   master : producer of input beats and consumer of output beats
//   slave  : the converter itself
interface msk_cols_bundle_serdes_if #(
  parameter int D  = 2,
  parameter int WC = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            in_mode;
  logic [WC*D-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [WC*D-1:0] out_data;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/msk_cols_bundle_serdes.sv
// msk_cols_bundle_serdes
//   Serial converter between the column and bundle layouts of a masked
//   Clyde state. NBITS/WC input beats fill a single buffer, then the
//   permuted state is streamed out over the same number of beats.
//   Whole sharings are relocated; shares are never combined.
// Ports:
//   clk   - rising-edge clock
//   nrst  - asynchronous active-low reset
//   clear - synchronous abort, wipes buffer/mode/counter
//   busy  - high unless idle in LOAD with counter at 0
//   bus   - slave side of the in/out handshake interface
//           (in_mode: 0 = cols->bundle, 1 = bundle->cols, taken on beat 0)
module msk_cols_bundle_serdes #(
  parameter int D     = 2,
  parameter int NBITS = 128,
  parameter int WC    = 32
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  output logic busy,
  msk_cols_bundle_serdes_if.slave bus
);
  localparam int BEATS = NBITS / WC;
  localparam int Q     = NBITS / 4;
  localparam int BW    = WC * D;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              mode_reg, mode_next;
  logic [NBITS*D-1:0] buf_reg;
  logic [NBITS*D-1:0] perm_c2b, perm_b2c, perm_sel;
  logic [BW-1:0]     out_beat;
  logic              in_fire, wipe, last_beat;

  assign last_beat = (cnt_reg == CW'(BEATS - 1));

  // Fixed wiring permutations: each D-bit sharing moves as a unit, so
  // share s always lands in share s of its destination.
  // cols index 4*i+r  <->  bundle index r*Q+i
  generate
    for (genvar gi = 0; gi < Q; gi++) begin : g_col
      for (genvar gr = 0; gr < 4; gr++) begin : g_row
        assign perm_c2b[(gr*Q+gi)*D +: D] = buf_reg[(4*gi+gr)*D +: D];
        assign perm_b2c[(4*gi+gr)*D +: D] = buf_reg[(gr*Q+gi)*D +: D];
      end
    end
  endgenerate

  assign perm_sel = mode_reg ? perm_b2c : perm_c2b;

  always_comb begin
    out_beat = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt_reg == CW'(b)) out_beat = perm_sel[b*BW +: BW];
    end
  end

  // Output data is forced to zero outside DRAIN so a partially loaded
  // buffer is never exposed and reset drives out_data low immediately.
  assign bus.out_data = (state_reg == DRAIN) ? out_beat : '0;
  assign busy         = !((state_reg == LOAD) && (cnt_reg == '0));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    mode_next     = mode_reg;
    in_fire       = 1'b0;
    wipe          = 1'b0;
    bus.in_ready  = (state_reg == LOAD);
    bus.out_valid = (state_reg == DRAIN);
    if (clear) begin
      // Abort: any concurrent handshake is discarded.
      state_next = LOAD;
      cnt_next   = '0;
      mode_next  = 1'b0;
      wipe       = 1'b1;
    end else begin
      case (state_reg)
        LOAD: begin
          if (bus.in_valid) begin
            in_fire = 1'b1;
            if (cnt_reg == '0) mode_next = bus.in_mode;
            if (last_beat) begin
              cnt_next   = '0;
              state_next = DRAIN;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (last_beat) begin
              cnt_next   = '0;
              state_next = LOAD;
              wipe       = 1'b1;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        end
        default: state_next = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      if (wipe) begin
        buf_reg <= '0;
      end else begin
        for (int b = 0; b < BEATS; b++) begin
          if (in_fire && (cnt_reg == CW'(b))) buf_reg[b*BW +: BW] <= bus.in_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_msk_cols_bundle_serdes.sv
// tb_msk_cols_bundle_serdes
//   Directed + randomized bench for two converter instances:
//   WC=32 (4 beats) and WC=128 (1 beat), both D=2, NBITS=128.
module tb_msk_cols_bundle_serdes;
  localparam int D  = 2;
  localparam int NB = 128;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic clear0 = 1'b0;
  logic clear1 = 1'b0;
  logic busy0, busy1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  msk_cols_bundle_serdes_if #(.D(D), .WC(32))  bus0 ();
  msk_cols_bundle_serdes_if #(.D(D), .WC(128)) bus1 ();

  msk_cols_bundle_serdes #(.D(D), .NBITS(NB), .WC(32)) dut0 (
    .clk(clk), .nrst(nrst), .clear(clear0), .busy(busy0), .bus(bus0));
  msk_cols_bundle_serdes #(.D(D), .NBITS(NB), .WC(128)) dut1 (
    .clk(clk), .nrst(nrst), .clear(clear1), .busy(busy1), .bus(bus1));

  // Reference permutation from the layout definitions:
  // cols index k = 4*i + r, bundle index = r*(NB/4) + i.
  function automatic logic [255:0] ref_perm(input logic [255:0] s, input bit mode);
    logic [255:0] res;
    int i, r, bidx;
    res = '0;
    for (int k = 0; k < NB; k++) begin
      i = k / 4;
      r = k % 4;
      bidx = r * (NB / 4) + i;
      if (!mode) res[bidx*D +: D] = s[k*D +: D];
      else       res[k*D +: D]    = s[bidx*D +: D];
    end
    return res;
  endfunction

  function automatic logic [255:0] rand_state();
    logic [255:0] s;
    for (int w = 0; w < 8; w++) s[w*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Four input beats on instance 0; modes[b] is driven on beat b.
  task automatic load0(input logic [255:0] st, input logic [3:0] modes);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus0.in_valid = 1'b1;
      bus0.in_data  = st[b*64 +: 64];
      bus0.in_mode  = modes[b];
      check("load_in_ready", 256'(bus0.in_ready), 256'(1));
      check("load_no_out_valid", 256'(bus0.out_valid), 256'(0));
    end
    @(negedge clk);
    bus0.in_valid = 1'b0;
    bus0.in_data  = {$urandom, $urandom};
    bus0.in_mode  = 1'($urandom);
    check("first_out_valid_latency", 256'(bus0.out_valid), 256'(1));
  endtask

  // Drain instance 0, stalling 3 cycles on beat stall_beat (-1 = none).
  task automatic drain0(input logic [255:0] exp, input int stall_beat, output logic [255:0] got);
    got = '0;
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        for (int s = 0; s < 3; s++) begin
          bus0.out_ready = 1'b0;
          check("stall_out_valid", 256'(bus0.out_valid), 256'(1));
          check("stall_out_data", 256'(bus0.out_data), 256'(exp[b*64 +: 64]));
          @(negedge clk);
        end
      end
      check("drain_in_ready_low", 256'(bus0.in_ready), 256'(0));
      check("drain_out_valid", 256'(bus0.out_valid), 256'(1));
      check("drain_beat", 256'(bus0.out_data), 256'(exp[b*64 +: 64]));
      got[b*64 +: 64] = bus0.out_data;
      bus0.out_ready = 1'b1;
      @(negedge clk);
    end
    bus0.out_ready = 1'b0;
    check("post_drain_out_valid", 256'(bus0.out_valid), 256'(0));
    check("post_drain_busy", 256'(busy0), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] st, st2, got, got2, expv, mask;
    bit m;
    int stall;

    bus0.in_valid = 0; bus0.in_mode = 0; bus0.in_data = '0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.in_mode = 0; bus1.in_data = '0; bus1.out_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 256'(bus0.in_ready), 256'(1));
    check("rst_out_valid", 256'(bus0.out_valid), 256'(0));
    check("rst_out_data", 256'(bus0.out_data), 256'(0));
    check("rst_busy", 256'(busy0), 256'(0));
    check("rst1_in_ready", 256'(bus1.in_ready), 256'(1));
    nrst = 1'b1;

    // Directed: single sharing 4 = 11 (col 1, row 0) -> bundle index 1
    st = '0; st[4*D +: D] = 2'b11;
    load0(st, 4'b0000);
    drain0(ref_perm(st, 1'b0), -1, got);
    check("dir_s4_bits", 256'(got[3:2]), 256'(2'b11));
    mask = '1; mask[3:2] = 2'b00;
    check("dir_s4_rest", got & mask, 256'(0));

    // Directed: sharing 5 = 01 (col 1, row 1) -> bundle index 33, beat 1
    st = '0; st[5*D +: D] = 2'b01;
    load0(st, 4'b0000);
    drain0(ref_perm(st, 1'b0), -1, got);
    check("dir_s5_bits", 256'(got[67:66]), 256'(2'b01));
    mask = '1; mask[67:66] = 2'b00;
    check("dir_s5_rest", got & mask, 256'(0));

    // Round trip: cols->bundle then bundle->cols restores the state
    st = rand_state();
    load0(st, 4'b0000);
    drain0(ref_perm(st, 1'b0), -1, got);
    load0(got, 4'b1111);
    drain0(st, -1, got2);
    check("round_trip", got2, st);

    // Backpressure on beat 2
    st = rand_state();
    m = 1'($urandom);
    load0(st, {4{m}});
    drain0(ref_perm(st, m), 2, got);

    // Mode captured on beat 0 only
    st = rand_state();
    load0(st, 4'b1110);
    drain0(ref_perm(st, 1'b0), -1, got);

    // clear during beat 2 of LOAD
    st = rand_state();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus0.in_valid = 1'b1; bus0.in_data = st[b*64 +: 64]; bus0.in_mode = 1'b1;
    end
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.in_data = st[128 +: 64]; clear0 = 1'b1;
    @(negedge clk);
    bus0.in_valid = 1'b0; clear0 = 1'b0;
    check("clear_busy", 256'(busy0), 256'(0));
    check("clear_out_valid", 256'(bus0.out_valid), 256'(0));
    check("clear_in_ready", 256'(bus0.in_ready), 256'(1));
    st2 = rand_state();
    load0(st2, 4'b0000);
    drain0(ref_perm(st2, 1'b0), -1, got);

    // Asynchronous reset mid-DRAIN
    st = rand_state();
    load0(st, 4'b0000);
    bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.out_ready = 1'b0;
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("arst_out_valid", 256'(bus0.out_valid), 256'(0));
    check("arst_in_ready", 256'(bus0.in_ready), 256'(1));
    check("arst_out_data", 256'(bus0.out_data), 256'(0));
    check("arst_busy", 256'(busy0), 256'(0));
    @(negedge clk);
    nrst = 1'b1;

    // Randomized transfers
    for (int t = 0; t < 6; t++) begin
      st = rand_state();
      m = 1'($urandom);
      stall = $urandom_range(0, 4) - 1;
      load0(st, {4{m}});
      drain0(ref_perm(st, m), stall, got);
    end

    // Single-beat instance (WC = NBITS)
    for (int t = 0; t < 4; t++) begin
      st = rand_state();
      m = 1'($urandom);
      @(negedge clk);
      bus1.in_valid = 1'b1; bus1.in_data = st; bus1.in_mode = m;
      check("b1_in_ready", 256'(bus1.in_ready), 256'(1));
      @(negedge clk);
      bus1.in_valid = 1'b0;
      check("b1_out_valid", 256'(bus1.out_valid), 256'(1));
      check("b1_in_ready_low", 256'(bus1.in_ready), 256'(0));
      check("b1_busy", 256'(busy1), 256'(1));
      check("b1_out_data", bus1.out_data, ref_perm(st, m));
      bus1.out_ready = 1'b1;
      @(negedge clk);
      bus1.out_ready = 1'b0;
      check("b1_post_out_valid", 256'(bus1.out_valid), 256'(0));
      check("b1_post_busy", 256'(busy1), 256'(0));
    end

    // Single-beat instance: asynchronous reset while DRAIN
    st = rand_state();
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_data = st; bus1.in_mode = 1'b0;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check("b1_pre_arst_out_valid", 256'(bus1.out_valid), 256'(1));
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("b1_arst_out_valid", 256'(bus1.out_valid), 256'(0));
    check("b1_arst_in_ready", 256'(bus1.in_ready), 256'(1));
    check("b1_arst_out_data", bus1.out_data, 256'(0));
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/msk_cols_bundle_serdes.md
Name: msk_cols_bundle_serdes

Overview:
- Serial, handshaked converter between the column and bundle representations of a masked Clyde state.
- Accepts the state as Nbits sharings over several input beats into a single buffer, then streams the permuted state out over the same number of beats.
- The direction is selectable per transfer.
- Sits between the serial state load/unload path and the masked round datapath of the masked Clyde core.
- Only relocates whole sharings; never combines shares.

Parameters:
- d, 2, number of masking shares per sharing.
- Nbits, 128, state bits (sharings); must be a multiple of 4 and of Wc.
- Wc, 32, sharings per beat; must divide Nbits. Beats = Nbits/Wc.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort and buffer wipe.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts an input beat.
- in_mode  in  1  direction; 0 = cols->bundle, 1 = bundle->cols; sampled on the first beat only.
- in_data  in  Wc*d  input beat; sharing j at bits [j*d+d-1:j*d].
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts an output beat.
- out_data  out  Wc*d  output beat, same packing as in_data.
- busy  out  1  high whenever the state is not LOAD with beat counter 0.

Behaviour:
- Formats:
  - Global sharing index k occupies state bits [k*d+d-1:k*d].
  - Cols: k = 4*i + r (column i in 0..Nbits/4-1, row r in 0..3).
  - Bundle: k = r*(Nbits/4) + i.
  - cols->bundle: bundle[r*Nbits/4+i] = cols[4i+r]. bundle->cols is the exact inverse.
- Beat order: beat b carries global sharings b*Wc .. b*Wc+Wc-1. Beat 0 is sent first, on both input and output.
- FSM states: LOAD, DRAIN. Beat counter width = max(1, clog2(Beats)).
- LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready, the beat is written into buffer slot cnt and cnt increments.
  - On cnt==0 the mode register captures in_mode.
  - On the final beat (cnt==Beats-1): cnt<=0 and the state goes to DRAIN.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_data = beat cnt of perm(buffer, mode), read from registers with no combinational path from in_data.
  - On out_ready: cnt increments. On the final beat: cnt<=0, the buffer is zeroed and the state goes to LOAD.
- Latency: first output beat is valid in the cycle after the final input beat is accepted. Full throughput is Beats in + Beats out cycles per state; input and output do not overlap (single buffer).
- out_data is held stable while out_valid&!out_ready. The out_valid/out_data pair never changes without a handshake except on clear or reset.
- clear (synchronous, highest priority after reset):
  - state<=LOAD, cnt<=0, mode<=0, buffer<=0.
  - Any concurrent input or output handshake is discarded.
- Reset (asynchronous, nrst low, any state including mid-DRAIN):
  - state=LOAD, cnt=0, mode=0, buffer=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- Beats=1: LOAD and DRAIN each last one handshake; the counter is unused but present.
- in_valid while in_ready=0 is ignored. in_data and in_mode are don't-care when in_valid=0.
- Security: the buffer and output registers are plain flops with a fixed wiring permutation. Share s of a sharing always lands in share s of its destination. No share XOR or mux between shares of different indices.

Test Plan:
- d=2,Nbits=128,Wc=32, mode 0: only cols sharing 4 = 2'b11 (i=1,r=0), rest 0, 4 beats in -> out beat0 bits[3:2]=11, all other output bits 0. Then only sharing 5 = 2'b01 -> out beat1 bits[3:2]=01.
- Round trip with random 256-bit state: mode 0 then feed outputs back with mode 1 -> final output equals the original; first out_valid exactly 1 cycle after the 4th input handshake.
- Backpressure: out_ready low for 3 cycles on beat 2 -> out_data constant and out_valid high throughout; in_ready=0 for the whole DRAIN; no beat lost or duplicated.
- Mode sampling: in_mode=0 on beat 0, toggled to 1 on beats 1-3 -> result is cols->bundle.
- clear asserted during beat 2 of LOAD (with in_valid) -> next cycle cnt=0, busy=0. A fresh 4-beat load produces output matching that load only; internal buffer is zero after clear.
- nrst pulsed mid-DRAIN (asynchronously, between edges) -> out_valid=0, in_ready=1, out_data=0 immediately. Repeat with Wc=128 (Beats=1): each in/out handshake is a single beat with correct permutation.
